// File: rtl/gate_selftest_if.sv
// Signal bundle between the gate self-test driver and the two-input gate block under test.
// The master side is the self-test driver; the slave side is the gate block plus the run controller.
interface gate_selftest_if;
  logic       start;
  logic       a_drv;
  logic       b_drv;
  logic       and_in;
  logic       or_in;
  logic       not_in;
  logic       xor_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_vec;
  logic [3:0] err_gate;

  modport master (
    input  start, and_in, or_in, not_in, xor_in,
    output a_drv, b_drv, busy, done, pass, fail_vec, err_gate
  );

  modport slave (
    output start, and_in, or_in, not_in, xor_in,
    input  a_drv, b_drv, busy, done, pass, fail_vec, err_gate
  );
endinterface

// File: rtl/gate_selftest.sv
// Walks a/b through 00,01,10,11, waits SETTLE_CYCLES per vector, then checks AND/OR/NOT/XOR against golden values.
// A run lasts 4*(SETTLE_CYCLES+1) cycles from the accepting edge; start is ignored unless idle, and there is no backpressure.
module gate_selftest #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  gate_selftest_if.master bus
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("gate_selftest: SETTLE_CYCLES must be within 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] fail_vec_q, fail_vec_d;
  logic [3:0] err_gate_q, err_gate_d;
  logic [3:0] mism;
  logic [1:0] vec_nxt;

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    fail_vec_d = fail_vec_q;
    err_gate_d = err_gate_q;
    mism       = 4'b0000;
    vec_nxt    = vec_q + 2'd1;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          vec_d      = 2'd0;
          cnt_d      = 4'd0;
          a_d        = 1'b0;
          b_d        = 1'b0;
          fail_vec_d = 4'b0000;
          err_gate_d = 4'b0000;
          pass_d     = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_CHECK: begin
        // bit order matches err_gate: AND, OR, NOT, XOR
        mism[0] = bus.and_in != (a_q & b_q);
        mism[1] = bus.or_in  != (a_q | b_q);
        mism[2] = bus.not_in != ~a_q;
        mism[3] = bus.xor_in != (a_q ^ b_q);
        err_gate_d = err_gate_q | mism;
        if (|mism) begin
          fail_vec_d[vec_q] = 1'b1;
        end
        if (vec_q == 2'd3) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = ~|fail_vec_d;
          state_d = S_DONE;
        end else begin
          vec_d   = vec_nxt;
          a_d     = vec_nxt[1];
          b_d     = vec_nxt[0];
          cnt_d   = 4'd0;
          state_d = S_SETTLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      vec_q      <= 2'd0;
      cnt_q      <= 4'd0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_vec_q <= 4'b0000;
      err_gate_q <= 4'b0000;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_vec_q <= fail_vec_d;
      err_gate_q <= err_gate_d;
    end
  end

  assign bus.a_drv    = a_q;
  assign bus.b_drv    = b_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.fail_vec = fail_vec_q;
  assign bus.err_gate = err_gate_q;

endmodule

// File: tb/tb_gate_selftest.sv
// Bench for gate_selftest: a behavioural gate model with stuck-at knobs feeds two instances (settle 2 and 1).
// Expected run results are queued at start and compared when done pulses.
module tb_gate_selftest;

  typedef struct packed {
    logic [3:0] fv;
    logic [3:0] eg;
    logic       ps;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic start_r = 1'b0;
  logic stuck_and0 = 1'b0;
  logic stuck_not1 = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  gate_selftest_if u_if2 ();
  gate_selftest_if u_if1 ();

  gate_selftest #(.SETTLE_CYCLES(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(u_if2.master));
  gate_selftest #(.SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(u_if1.master));

  assign u_if2.start  = start_r & ~sel;
  assign u_if1.start  = start_r & sel;
  assign u_if2.and_in = stuck_and0 ? 1'b0 : (u_if2.a_drv & u_if2.b_drv);
  assign u_if2.or_in  = u_if2.a_drv | u_if2.b_drv;
  assign u_if2.not_in = stuck_not1 ? 1'b1 : ~u_if2.a_drv;
  assign u_if2.xor_in = u_if2.a_drv ^ u_if2.b_drv;
  assign u_if1.and_in = stuck_and0 ? 1'b0 : (u_if1.a_drv & u_if1.b_drv);
  assign u_if1.or_in  = u_if1.a_drv | u_if1.b_drv;
  assign u_if1.not_in = stuck_not1 ? 1'b1 : ~u_if1.a_drv;
  assign u_if1.xor_in = u_if1.a_drv ^ u_if1.b_drv;

  logic       obs_a, obs_b, obs_busy, obs_done, obs_pass;
  logic [3:0] obs_fv, obs_eg;
  assign obs_a    = sel ? u_if1.a_drv    : u_if2.a_drv;
  assign obs_b    = sel ? u_if1.b_drv    : u_if2.b_drv;
  assign obs_busy = sel ? u_if1.busy     : u_if2.busy;
  assign obs_done = sel ? u_if1.done     : u_if2.done;
  assign obs_pass = sel ? u_if1.pass     : u_if2.pass;
  assign obs_fv   = sel ? u_if1.fail_vec : u_if2.fail_vec;
  assign obs_eg   = sel ? u_if1.err_gate : u_if2.err_gate;

  // One full run on the selected instance, checked cycle by cycle from the accepting edge.
  task automatic run_check(input int s, input logic [3:0] fv, input logic [3:0] eg, input bit extra,
                           input bit prestarted, input bit chain, input string name);
    int         lat;
    int         ndone;
    exp_t       e;
    logic [1:0] ab_exp;
    lat   = 4 * (s + 1);
    ndone = 0;
    sel   = (s == 1);
    sb.push_back('{fv: fv, eg: eg, ps: (fv == 4'b0000)});
    if (!prestarted) start_r = 1'b1;
    for (int cyc = 0; cyc <= lat + 3; cyc++) begin
      @(posedge clk);
      #1;
      start_r = (extra && cyc <= lat) || (chain && cyc == lat + 1);
      if (cyc < lat) ab_exp = 2'(cyc / (s + 1));
      else ab_exp = 2'b11;
      total++;
      if ({obs_a, obs_b} !== ab_exp) begin
        bad++;
        $display("FAIL %s drive cyc=%0d got=%b want=%b", name, cyc, {obs_a, obs_b}, ab_exp);
      end
      total++;
      if (obs_busy !== (cyc < lat)) begin
        bad++;
        $display("FAIL %s busy cyc=%0d got=%b want=%b", name, cyc, obs_busy, (cyc < lat));
      end
      total++;
      if (obs_done !== (cyc == lat)) begin
        bad++;
        $display("FAIL %s done cyc=%0d got=%b want=%b", name, cyc, obs_done, (cyc == lat));
      end
      if (obs_done === 1'b1) begin
        ndone++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL %s unexpected_done cyc=%0d got=1 want=0", name, cyc);
        end else begin
          e = sb.pop_front();
          if ({obs_fv, obs_eg, obs_pass} !== {e.fv, e.eg, e.ps}) begin
            bad++;
            $display("FAIL %s result fv/eg/pass got=%b/%b/%b want=%b/%b/%b",
                     name, obs_fv, obs_eg, obs_pass, e.fv, e.eg, e.ps);
          end
        end
      end
      if (cyc == 0) begin
        total++;
        if ({obs_fv, obs_eg, obs_pass} !== 9'b0) begin
          bad++;
          $display("FAIL %s clear_on_start got=%b/%b/%b want=0000/0000/0", name, obs_fv, obs_eg, obs_pass);
        end
      end
      if (chain && cyc == lat + 1) return;
    end
    total++;
    if (ndone != 1) begin
      bad++;
      $display("FAIL %s done_count got=%0d want=1", name, ndone);
    end
    total++;
    if ({obs_fv, obs_eg, obs_pass} !== {fv, eg, (fv == 4'b0000)}) begin
      bad++;
      $display("FAIL %s result_held got=%b/%b/%b want=%b/%b/%b",
               name, obs_fv, obs_eg, obs_pass, fv, eg, (fv == 4'b0000));
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s missing_done got=%0d pending want=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) begin
      sel = (i == 1);
      #1;
      total++;
      if ({obs_a, obs_b, obs_busy, obs_done, obs_pass, obs_fv, obs_eg} !== 13'b0) begin
        bad++;
        $display("FAIL reset_state inst=%0d got=%b want=0", i,
                 {obs_a, obs_b, obs_busy, obs_done, obs_pass, obs_fv, obs_eg});
      end
    end
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_ideal();
    run_check(2, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, "ideal");
  endtask

  task automatic test_and_stuck();
    stuck_and0 = 1'b1;
    run_check(2, 4'b1000, 4'b0001, 1'b0, 1'b0, 1'b0, "and_stuck0");
    stuck_and0 = 1'b0;
  endtask

  task automatic test_not_stuck();
    stuck_not1 = 1'b1;
    run_check(2, 4'b1100, 4'b0100, 1'b0, 1'b0, 1'b0, "not_stuck1");
    stuck_not1 = 1'b0;
  endtask

  task automatic test_extra_start();
    run_check(2, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, "extra_start");
  endtask

  task automatic test_reset_midrun();
    sel = 1'b0;
    start_r = 1'b1;
    @(posedge clk);
    #1;
    start_r = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    total++;
    if ({obs_a, obs_b, obs_busy} !== 3'b101) begin
      bad++;
      $display("FAIL midrun_vec2 got=%b want=101", {obs_a, obs_b, obs_busy});
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({obs_a, obs_b, obs_busy, obs_done, obs_pass, obs_fv, obs_eg} !== 13'b0) begin
      bad++;
      $display("FAIL async_reset got=%b want=0", {obs_a, obs_b, obs_busy, obs_done, obs_pass, obs_fv, obs_eg});
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (obs_done !== 1'b0 || obs_busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_no_done i=%0d got=%b%b want=00", i, obs_done, obs_busy);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_check(2, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    stuck_and0 = 1'b1;
    run_check(1, 4'b1000, 4'b0001, 1'b0, 1'b0, 1'b1, "b2b_first");
    stuck_and0 = 1'b0;
    run_check(1, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_and_stuck();
    test_not_stuck();
    test_extra_start();
    test_reset_midrun();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_selftest.md
# gate_selftest

Sequential self-test driver and checker for the two-input logic-gate stage. It sits directly upstream and downstream of the gate block. It drives the gate block's `a`/`b` inputs through all four input combinations and waits a programmable settle time for each. It then samples the AND, OR, NOT and XOR outputs, compares them against golden values, and reports pass/fail per input combination and per gate.

## Interface

Parameters:
- `SETTLE_CYCLES`, default 2: clock cycles between driving a vector and sampling the gate outputs.
  - Legal range is 1..15.
  - A value of 0 is an elaboration error.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a test run; honoured only in IDLE.
- `a_drv`  out  1  drives the gate block's `a` input.
- `b_drv`  out  1  drives the gate block's `b` input.
- `and_in`  in  1  the gate block's AND output.
- `or_in`  in  1  the gate block's OR output.
- `not_in`  in  1  the gate block's NOT output (NOT of `a`).
- `xor_in`  in  1  the gate block's XOR output.
- `busy`  out  1  high from the edge that accepts `start` until the edge that enters DONE.
- `done`  out  1  one-cycle pulse at the end of a run.
- `pass`  out  1  high when the last completed run had no mismatch; held until the next accepted `start`.
- `fail_vec`  out  4  bit i set when vector i had any mismatch.
- `err_gate`  out  4  sticky per-gate error: bit0 AND, bit1 OR, bit2 NOT, bit3 XOR.

## Operation

- States:
  - IDLE
  - SETTLE: counter `cnt` runs 0..SETTLE_CYCLES-1.
  - CHECK
  - DONE
- Vector order: index `vec` runs 0,1,2,3, with `a_drv` = `vec[1]` and `b_drv` = `vec[0]`. This gives (a,b) = 00, 01, 10, 11.
- IDLE, when `start`=1:
  - `vec` and `cnt` go to 0; `a_drv` and `b_drv` go to 0.
  - `fail_vec`, `err_gate` and `pass` clear to 0; `busy` goes to 1.
  - Next state is SETTLE.
- SETTLE:
  - `cnt` increments each cycle.
  - When `cnt` = SETTLE_CYCLES-1, go to CHECK.
- CHECK, comparing the inputs with the golden values a&b, a|b, ~a, a^b for the current `a_drv`/`b_drv`:
  - Any mismatch sets `fail_vec[vec]` and the matching `err_gate` bit(s). These bits are never cleared mid-run.
  - If `vec` < 3: increment `vec`, update `a_drv`/`b_drv`, clear `cnt`, go to SETTLE.
  - If `vec` = 3: go to DONE, with `busy` going to 0 on that same edge.
- DONE:
  - `done` = 1 for exactly this one cycle.
  - `pass` is registered to NOR of the final `fail_vec`, including any bit set in the last CHECK.
  - Next state is IDLE.
- In DONE, `a_drv`/`b_drv` hold at 1/1. They return to 0 only on the next accepted `start` or on reset.
- `start` in SETTLE, CHECK or DONE is ignored. It is not queued.
- All outputs are registered. No combinational path exists from `*_in` to any output.

## Timing

- Reset values:
  - `a_drv` = 0, `b_drv` = 0
  - `busy` = 0, `done` = 0, `pass` = 0
  - `fail_vec` = 0, `err_gate` = 0
  - state IDLE, `vec` = 0, `cnt` = 0
- Reset is asynchronous: outputs reach their reset values immediately when `rst_n` falls, including mid-run.
  - No `done` pulse is generated for an aborted run.
- After `rst_n` rises, the first edge can accept `start`.
- Per vector: SETTLE_CYCLES cycles in SETTLE plus 1 cycle in CHECK.
- Let E0 be the edge that accepts `start`.
  - `done` is high in the cycle following edge E0 + 4·(SETTLE_CYCLES+1).
  - With the default of 2, that is edge E12.
- The gate outputs are sampled at the edge leaving CHECK. The drive for a vector has therefore been stable for SETTLE_CYCLES+1 edges before sampling.
- The earliest accepted restart is the edge after DONE, i.e. the first IDLE cycle.

## Test plan

- Ideal gate model, SETTLE_CYCLES=2, single `start`:
  - (a,b) sequence 00→01→10→11, each held 3 cycles.
  - `done` pulse after E12.
  - `pass`=1, `fail_vec`=0000, `err_gate`=0000.
- `and_in` stuck at 0: `fail_vec`=1000, `err_gate`=0001, `pass`=0. `done` timing is unchanged.
- `not_in` stuck at 1: vectors 2 and 3 fail, giving `fail_vec`=1100, `err_gate`=0100, `pass`=0.
- Extra `start` pulses during SETTLE, CHECK and DONE:
  - Ignored; exactly one `done`.
  - `busy` is high for 12 cycles.
  - Results are identical to the ideal run.
- `rst_n` low during vector 2 (SETTLE):
  - All outputs are 0 immediately and no `done` occurs.
  - A `start` after release gives a full, correct run.
- SETTLE_CYCLES=1, with a failing run followed by `start` in the first IDLE cycle after DONE:
  - `fail_vec`, `err_gate` and `pass` clear at the accepting edge.
  - The second `done` comes after E8 relative to that edge.
